mips_hazard_ctrl: RTL and testbench

- Interlock/sequencing controller for the 5-stage pipe_MIPS32 (IF, ID, EX, MEM, WB).
- Replaces software-inserted dummy instructions. It tracks pending register writes in a scoreboard, stalls IF/ID on RAW hazards, squashes wrong-path instructions on a taken branch, and drains the pipe on HLT.
- Sits beside the pipeline registers and drives their write-enable, bubble and flush controls.

---
 rtl/mips_pkg.sv | 57 +++++
 rtl/mips_hazard_decode.sv | 75 +++++++
 rtl/mips_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_mips_hazard_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, instruction classes and field positions for pipe_MIPS32
package mips_pkg;

  // Opcode map
  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  // Instruction field positions
  localparam int OP_LSB = 26;
  localparam int OP_W   = 6;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  typedef enum logic [2:0] {
    CLS_RR_ALU,
    CLS_RM_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_HALT,
    CLS_OTHER
  } instr_class_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } ctrl_state_e;

  function automatic instr_class_e classify(input logic [5:0] op);
    instr_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = CLS_RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                    cls = CLS_RM_ALU;
      OP_LW:                                        cls = CLS_LOAD;
      OP_SW:                                        cls = CLS_STORE;
      OP_BNEQZ, OP_BEQZ:                            cls = CLS_BRANCH;
      OP_HLT:                                       cls = CLS_HALT;
      default:                                      cls = CLS_OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips_hazard_decode.sv
// rtl/mips_hazard_decode.sv - maps an instruction to its register sources, destination and HLT flag
module mips_hazard_decode
  import mips_pkg::*;
#(
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic [31:0]   instr,
  output logic          src1_v,
  output logic [RW-1:0] src1,
  output logic          src2_v,
  output logic [RW-1:0] src2,
  output logic          dst_v,
  output logic [RW-1:0] dst,
  output logic          is_hlt
);

  logic [OP_W-1:0] opcode;
  logic [RW-1:0]   rs;
  logic [RW-1:0]   rt;
  logic [RW-1:0]   rd;
  logic            raw_src1_v;
  logic            raw_src2_v;
  logic            raw_dst_v;
  logic            unused_low_bits;

  assign opcode = instr[OP_LSB +: OP_W];
  assign rs     = instr[RS_LSB +: RW];
  assign rt     = instr[RT_LSB +: RW];
  assign rd     = instr[RD_LSB +: RW];

  // Immediate / shamt bits carry no register information
  assign unused_low_bits = ^instr[RD_LSB-1:0];

  // Per-class register usage
  always_comb begin
    raw_src1_v = 1'b0;
    raw_src2_v = 1'b0;
    raw_dst_v  = 1'b0;
    src1       = rs;
    src2       = rt;
    dst        = rd;
    is_hlt     = 1'b0;
    case (classify(opcode))
      CLS_RR_ALU: begin
        raw_src1_v = 1'b1;
        raw_src2_v = 1'b1;
        raw_dst_v  = 1'b1;
      end
      CLS_RM_ALU, CLS_LOAD: begin
        raw_src1_v = 1'b1;
        raw_dst_v  = 1'b1;
        dst        = rt;
      end
      CLS_STORE: begin
        raw_src1_v = 1'b1;
        raw_src2_v = 1'b1;
      end
      CLS_BRANCH: begin
        raw_src1_v = 1'b1;
      end
      CLS_HALT: begin
        is_hlt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // R0 is hard-wired zero: it is never a real producer or consumer
  assign src1_v = raw_src1_v & (src1 != '0);
  assign src2_v = raw_src2_v & (src2 != '0);
  assign dst_v  = raw_dst_v  & (dst  != '0);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - RAW interlock, branch squash and HLT drain control for the 5-stage pipe
module mips_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int RW = $clog2(NREG);

  logic          src1_v;
  logic [RW-1:0] src1;
  logic          src2_v;
  logic [RW-1:0] src2;
  logic          dst_v;
  logic [RW-1:0] dst;
  logic          is_hlt;

  mips_hazard_decode #(
    .NREG (NREG),
    .RW   (RW)
  ) u_decode (
    .instr  (id_instr),
    .src1_v (src1_v),
    .src1   (src1),
    .src2_v (src2_v),
    .src2   (src2),
    .dst_v  (dst_v),
    .dst    (dst),
    .is_hlt (is_hlt)
  );

  ctrl_state_e      state_q, state_d;
  logic [1:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             sb_ex_v_q, sb_ex_v_d;
  logic [RW-1:0]    sb_ex_dst_q, sb_ex_dst_d;
  logic             sb_mem_v_q, sb_mem_v_d;
  logic [RW-1:0]    sb_mem_dst_q, sb_mem_dst_d;

  logic             src1_hit;
  logic             src2_hit;
  logic             hazard;
  logic             issue;

  // A source hazards while its producer is still in EX or MEM; WB is write-through
  always_comb begin
    src1_hit = src1_v & ((sb_ex_v_q  & (sb_ex_dst_q  == src1)) |
                         (sb_mem_v_q & (sb_mem_dst_q == src1)));
    src2_hit = src2_v & ((sb_ex_v_q  & (sb_ex_dst_q  == src2)) |
                         (sb_mem_v_q & (sb_mem_dst_q == src2)));
    hazard   = id_valid & (src1_hit | src2_hit);
  end

  // Pipeline controls, stall counting and RUN/DRAIN/HALT sequencing
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    issue       = 1'b0;
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end else begin
          issue = id_valid;
          if (id_valid && is_hlt) begin
            // Stop fetching and discard anything younger than the HLT
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            state_d     = ST_DRAIN;
            drain_cnt_d = 2'd0;
          end
        end
      end
      ST_DRAIN: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        // Third drain cycle is the HLT's WB cycle
        if (drain_cnt_q == 2'd2) begin
          state_d     = ST_HALT;
          drain_cnt_d = 2'd0;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      ST_HALT: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Scoreboard advances every cycle; only an issuing writer enters sb_ex
  always_comb begin
    sb_mem_v_d   = sb_ex_v_q;
    sb_mem_dst_d = sb_ex_dst_q;
    sb_ex_v_d    = issue & dst_v;
    sb_ex_dst_d  = dst;
  end

  // State, counters and scoreboard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drain_cnt_q  <= 2'd0;
      stall_cnt_q  <= '0;
      sb_ex_v_q    <= 1'b0;
      sb_ex_dst_q  <= '0;
      sb_mem_v_q   <= 1'b0;
      sb_mem_dst_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      sb_ex_v_q    <= sb_ex_v_d;
      sb_ex_dst_q  <= sb_ex_dst_d;
      sb_mem_v_q   <= sb_mem_v_d;
      sb_mem_dst_q <= sb_mem_dst_d;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb/tb_mips_hazard_ctrl.sv - scoreboard bench for mips_hazard_ctrl
module tb_mips_hazard_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halted;
  logic [15:0] stall_count;

  mips_hazard_ctrl #(.NREG(32), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .halted          (halted),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, halted}
  localparam logic [4:0] O_ISSUE  = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_BRANCH = 5'b11110;
  localparam logic [4:0] O_HLTISS = 5'b01100;
  localparam logic [4:0] O_DRAIN  = 5'b00110;
  localparam logic [4:0] O_HALT   = 5'b00111;

  typedef struct {
    logic [20:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input logic r, input logic v, input logic [31:0] ins, input logic br,
                      input logic [4:0] o, input logic [15:0] cnt, input string nm);
    exp_t e;
    rst             = r;
    id_valid        = v;
    id_instr        = ins;
    ex_branch_taken = br;
    e.v    = {o, cnt};
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    exp_t        e;
    logic [20:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {pc_write, ifid_write, ifid_flush, idex_bubble, halted, stall_count};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got pc/ifw/flush/bubble/halted=%b stall_count=%0d, expected %b stall_count=%0d",
                 e.name, act[20:16], act[15:0], e.v[20:16], e.v[15:0]);
      end
    end
  end

  logic [31:0] hlt;
  logic [31:0] add_4_1_2;

  initial begin
    hlt       = enc_r(OP_HLT, 5'd0, 5'd0, 5'd0);
    add_4_1_2 = enc_r(OP_ADD, 5'd1, 5'd2, 5'd4);
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 32'd0, 0, O_ISSUE, 0, "reset");
    // Back-to-back dependency: two stall cycles
    step(0, 1, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd10), 0, O_ISSUE, 0, "t1_addi");
    step(0, 1, add_4_1_2, 0, O_STALL, 0, "t1_stall1");
    step(0, 1, add_4_1_2, 0, O_STALL, 1, "t1_stall2");
    step(0, 1, add_4_1_2, 0, O_ISSUE, 2, "t1_add_issue");
    // Distance 2: one stall; distance 3: none
    step(0, 1, enc_i(OP_ADDI, 5'd0, 5'd2, 16'd20), 0, O_ISSUE, 2, "t2_addi");
    step(0, 1, enc_r(OP_OR, 5'd7, 5'd7, 5'd7), 0, O_ISSUE, 2, "t2_or");
    step(0, 1, add_4_1_2, 0, O_STALL, 2, "t2_stall");
    step(0, 1, add_4_1_2, 0, O_ISSUE, 3, "t2_add_issue");
    step(0, 1, enc_r(OP_AND, 5'd10, 5'd11, 5'd9), 0, O_ISSUE, 3, "t2_and");
    step(0, 1, enc_r(OP_OR, 5'd13, 5'd14, 5'd12), 0, O_ISSUE, 3, "t2_or2");
    step(0, 1, enc_r(OP_ADD, 5'd4, 5'd3, 5'd5), 0, O_ISSUE, 3, "t2_dist3");
    // R0 never hazards
    step(0, 1, enc_i(OP_ADDI, 5'd0, 5'd0, 16'd5), 0, O_ISSUE, 3, "t3_addi_r0");
    step(0, 1, enc_r(OP_ADD, 5'd0, 5'd0, 5'd4), 0, O_ISSUE, 3, "t3_add_r0");
    // Taken branch beats hazard and squashes HLT
    step(0, 1, enc_r(OP_ADD, 5'd4, 5'd4, 5'd6), 1, O_BRANCH, 3, "t4_br_hazard");
    step(0, 1, hlt, 1, O_BRANCH, 3, "t4_br_hlt");
    step(0, 0, 32'd0, 0, O_ISSUE, 3, "t4_still_run");
    // Load then store consuming the loaded register
    step(0, 1, enc_i(OP_LW, 5'd0, 5'd3, 16'd0), 0, O_ISSUE, 3, "t7_lw");
    step(0, 1, enc_i(OP_SW, 5'd0, 5'd3, 16'd4), 0, O_STALL, 3, "t7_sw_stall1");
    step(0, 1, enc_i(OP_SW, 5'd0, 5'd3, 16'd4), 0, O_STALL, 4, "t7_sw_stall2");
    step(0, 1, enc_i(OP_SW, 5'd0, 5'd3, 16'd4), 0, O_ISSUE, 5, "t7_sw_issue");
    // Reset in the middle of a drain
    step(0, 1, hlt, 0, O_HLTISS, 5, "t6_hlt_issue");
    step(0, 0, 32'd0, 0, O_DRAIN, 5, "t6_drain1");
    step(1, 0, 32'd0, 0, O_ISSUE, 0, "t6_reset_drain");
    step(0, 0, 32'd0, 0, O_ISSUE, 0, "t6_after_reset");
    step(0, 1, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd10), 0, O_ISSUE, 0, "t6_addi");
    step(0, 1, add_4_1_2, 0, O_STALL, 0, "t6_stall1");
    step(0, 1, add_4_1_2, 0, O_STALL, 1, "t6_stall2");
    step(0, 1, add_4_1_2, 0, O_ISSUE, 2, "t6_add_issue");
    // HLT drain to HALT; hazards and branches ignored throughout
    step(0, 1, enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1), 0, O_ISSUE, 2, "t5_addi");
    step(0, 1, hlt, 0, O_HLTISS, 2, "t5_hlt_issue");
    step(0, 1, add_4_1_2, 0, O_DRAIN, 2, "t5_drain1_hazard");
    step(0, 1, add_4_1_2, 1, O_DRAIN, 2, "t5_drain2_branch");
    step(0, 1, add_4_1_2, 0, O_DRAIN, 2, "t5_drain3");
    step(0, 1, add_4_1_2, 0, O_HALT, 2, "t5_halted");
    step(0, 1, add_4_1_2, 1, O_HALT, 2, "t5_halt_hold");
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_queue: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
